// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encoding and
// helpers that size the burst counter and requester index from parameters.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  // Counter wide enough to hold 0..burst-1; never narrower than one bit.
  function automatic int cnt_width(input int burst);
    return (burst <= 2) ? 1 : $clog2(burst);
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the one-hot first requester
// found searching upward from last_winner+1, wrapping modulo N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_winner,
  output logic [N-1:0]  winner
);

  int            sum;
  logic [IW-1:0] sel;

  // Walk offsets from farthest to nearest so the nearest requester is the
  // final assignment and therefore the winner.
  always_comb begin
    winner = '0;
    sum    = 0;
    sel    = '0;
    for (int k = N; k >= 1; k--) begin
      sum = int'(last_winner) + k;
      if (sum >= N) sum = sum - N;
      sel = IW'(sum);
      if (req[sel]) begin
        winner      = '0;
        winner[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter moving bursts of words from N requesters into one
// downstream FIFO. Optional macro FIFO_ARB_PRIO0_EN gives requester 0 priority.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int B     = 8,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic [N*B-1:0] req_data,
  input  logic [N-1:0] req_last,
  output logic [N-1:0] ack,
  output logic [N-1:0] grant,
  input  logic         fifo_full,
  output logic         fifo_wr,
  output logic [B-1:0] fifo_w_data,
  output logic         busy
);

  localparam int CW = cnt_width(BURST);
  localparam int IW = idx_width(N);

  state_t        state;
  logic [IW-1:0] gidx;
  logic [IW-1:0] last_winner;
  logic [CW-1:0] cnt;

  logic [N-1:0]  rr_win;
  logic [N-1:0]  pick;
  logic [IW-1:0] pick_idx;
  logic [B-1:0]  words [N];
  logic          req_g;
  logic          last_g;
  logic          at_limit;
  logic          release_now;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .req         (req),
    .last_winner (last_winner),
    .winner      (rr_win)
  );

  always_comb begin
`ifdef FIFO_ARB_PRIO0_EN
    pick = req[0] ? {{(N-1){1'b0}}, 1'b1} : rr_win;
`else
    pick = rr_win;
`endif
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      words[i] = req_data[i*B +: B];
    end
  end

  // Write path is combinational so a word is consumed the cycle it is offered.
  assign req_g       = req[gidx];
  assign last_g      = req_last[gidx];
  assign at_limit    = (cnt == CW'(BURST - 1));
  assign fifo_wr     = (state == ST_XFER) && req_g && !fifo_full;
  assign ack         = fifo_wr ? grant : '0;
  assign fifo_w_data = words[gidx];
  assign busy        = (state == ST_XFER);
  assign release_now = (state == ST_XFER) &&
                       (!req_g || (fifo_wr && (last_g || at_limit)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant       <= '0;
      gidx        <= '0;
      cnt         <= '0;
      last_winner <= IW'(N - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant <= pick;
            gidx  <= pick_idx;
            cnt   <= '0;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (release_now) begin
            state       <= ST_IDLE;
            grant       <= '0;
            last_winner <= gidx;
          end else if (fifo_wr) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(fifo_wr && fifo_full));
  a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(grant));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int B     = 8;
  localparam int BURST = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*B-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           fifo_full;
  logic           fifo_wr;
  logic [B-1:0]   fifo_w_data;
  logic           busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N     (N),
    .B     (B),
    .BURST (BURST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .ack         (ack),
    .grant       (grant),
    .fifo_full   (fifo_full),
    .fifo_wr     (fifo_wr),
    .fifo_w_data (fifo_w_data),
    .busy        (busy)
  );

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [B-1:0] w, input logic l);
    req_data[i*B +: B] = w;
    req_last[i]        = l;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    after_edge();
    after_edge();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req       = '1;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    @(negedge clk);
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant); end
    vectors++; if (ack !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_ack: got %b expected 0000", ack); end
    vectors++; if (fifo_wr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr: got %b expected 0", fifo_wr); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    after_edge();
    reset = 1'b0;
    req   = '0;
  endtask

  task automatic test_single_packet();
    do_reset();
    req = 4'b0001;
    set_word(0, 8'hA1, 1'b0);
    @(negedge clk);
    vectors++; if (grant !== 4'b0000 || fifo_wr !== 1'b0) begin miscompares++; $display("[TB] FAIL c1_idle: grant %b wr %b expected 0000 0", grant, fifo_wr); end
    after_edge();
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      vectors++; if (grant !== 4'b0001) begin miscompares++; $display("[TB] FAIL c1_grant[%0d]: got %b expected 0001", w, grant); end
      vectors++; if (ack !== 4'b0001 || fifo_wr !== 1'b1) begin miscompares++; $display("[TB] FAIL c1_ack[%0d]: ack %b wr %b expected 0001 1", w, ack, fifo_wr); end
      vectors++; if (fifo_w_data !== 8'(8'hA1 + w)) begin miscompares++; $display("[TB] FAIL c1_data[%0d]: got %h expected %h", w, fifo_w_data, 8'(8'hA1 + w)); end
      after_edge();
      if (w < 2) set_word(0, 8'(8'hA2 + w), (w == 1));
      else req = '0;
    end
    @(negedge clk);
    vectors++; if (grant !== 4'b0000 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL c1_release: grant %b busy %b expected 0000 0", grant, busy); end
    after_edge();
  endtask

  task automatic test_round_robin();
    int sent[N];
    int g;
    do_reset();
    for (int i = 0; i < N; i++) begin
      sent[i] = 0;
      set_word(i, 8'(i * 16), 1'b0);
    end
    req = '1;
    for (int b = 0; b < 5; b++) begin
      g = b % N;
      @(negedge clk);
      vectors++; if (grant !== 4'b0000 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL c2_idle[%0d]: grant %b busy %b expected 0000 0", b, grant, busy); end
      after_edge();
      for (int w = 0; w < BURST; w++) begin
        @(negedge clk);
        vectors++; if (grant !== 4'(1 << g)) begin miscompares++; $display("[TB] FAIL c2_grant[%0d.%0d]: got %b expected %b", b, w, grant, 4'(1 << g)); end
        vectors++; if (ack !== 4'(1 << g) || fifo_wr !== 1'b1) begin miscompares++; $display("[TB] FAIL c2_ack[%0d.%0d]: ack %b wr %b", b, w, ack, fifo_wr); end
        vectors++; if (fifo_w_data !== 8'(g * 16 + sent[g])) begin miscompares++; $display("[TB] FAIL c2_data[%0d.%0d]: got %h expected %h", b, w, fifo_w_data, 8'(g * 16 + sent[g])); end
        if (ack[g] === 1'b1) sent[g]++;
        after_edge();
        set_word(g, 8'(g * 16 + sent[g]), 1'b0);
      end
    end
    req = '0;
    after_edge();
  endtask

  task automatic test_full_stall();
    int writes = 0;
    int k = 0;
    do_reset();
    req = 4'b0001;
    set_word(0, 8'hC0, 1'b0);
    @(negedge clk);
    after_edge();
    for (int c = 0; c < 2 + 5 + 2; c++) begin
      fifo_full = (c >= 2 && c < 7);
      #1;
      @(negedge clk);
      if (fifo_full) begin
        vectors++; if (fifo_wr !== 1'b0 || ack !== 4'b0000) begin miscompares++; $display("[TB] FAIL c3_stall[%0d]: wr %b ack %b expected 0 0000", c, fifo_wr, ack); end
        vectors++; if (grant !== 4'b0001) begin miscompares++; $display("[TB] FAIL c3_hold[%0d]: grant %b expected 0001", c, grant); end
      end else begin
        vectors++; if (fifo_wr !== 1'b1 || fifo_w_data !== 8'(8'hC0 + k)) begin miscompares++; $display("[TB] FAIL c3_write[%0d]: wr %b data %h expected 1 %h", c, fifo_wr, fifo_w_data, 8'(8'hC0 + k)); end
      end
      if (fifo_wr === 1'b1) begin
        writes++;
        k++;
      end
      after_edge();
      set_word(0, 8'(8'hC0 + k), 1'b0);
    end
    fifo_full = 1'b0;
    @(negedge clk);
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("[TB] FAIL c3_release: grant %b expected 0000", grant); end
    vectors++; if (writes !== 4) begin miscompares++; $display("[TB] FAIL c3_count: got %0d writes expected 4", writes); end
    req = '0;
    after_edge();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b0010;
    set_word(1, 8'h11, 1'b1);
    @(negedge clk);
    after_edge();
    @(negedge clk);
    vectors++; if (grant !== 4'b0010 || fifo_wr !== 1'b1) begin miscompares++; $display("[TB] FAIL c4_first: grant %b wr %b expected 0010 1", grant, fifo_wr); end
    after_edge();
    req = 4'b0100;
    set_word(2, 8'h21, 1'b0);
    @(negedge clk);
    after_edge();
    @(negedge clk);
    vectors++; if (grant !== 4'b0100 || fifo_w_data !== 8'h21) begin miscompares++; $display("[TB] FAIL c4_word1: grant %b data %h expected 0100 21", grant, fifo_w_data); end
    after_edge();
    set_word(2, 8'h22, 1'b0);
    reset = 1'b1;
    #1;
    vectors++; if (fifo_wr !== 1'b0 || ack !== 4'b0000) begin miscompares++; $display("[TB] FAIL c4_abort: wr %b ack %b expected 0 0000", fifo_wr, ack); end
    vectors++; if (grant !== 4'b0000 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL c4_abort_state: grant %b busy %b expected 0000 0", grant, busy); end
    after_edge();
    reset = 1'b0;
    req   = 4'b1111;
    for (int i = 0; i < N; i++) set_word(i, 8'(8'h50 + i), 1'b0);
    @(negedge clk);
    after_edge();
    @(negedge clk);
    vectors++; if (grant !== 4'b0001) begin miscompares++; $display("[TB] FAIL c4_winner: grant %b expected 0001", grant); end
    req = '0;
    after_edge();
  endtask

  task automatic test_drop_req();
    do_reset();
    req = 4'b0011;
    set_word(0, 8'h31, 1'b0);
    set_word(1, 8'h41, 1'b0);
    @(negedge clk);
    after_edge();
    @(negedge clk);
    vectors++; if (grant !== 4'b0001 || fifo_w_data !== 8'h31 || fifo_wr !== 1'b1) begin miscompares++; $display("[TB] FAIL c5_write: grant %b wr %b data %h", grant, fifo_wr, fifo_w_data); end
    after_edge();
    req[0] = 1'b0;
    @(negedge clk);
    vectors++; if (fifo_wr !== 1'b0 || ack !== 4'b0000) begin miscompares++; $display("[TB] FAIL c5_drop: wr %b ack %b expected 0 0000", fifo_wr, ack); end
    after_edge();
    @(negedge clk);
    vectors++; if (grant !== 4'b0000 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL c5_idle: grant %b busy %b expected 0000 0", grant, busy); end
    after_edge();
    @(negedge clk);
    vectors++; if (grant !== 4'b0010 || ack !== 4'b0010 || fifo_w_data !== 8'h41) begin miscompares++; $display("[TB] FAIL c5_next: grant %b ack %b data %h expected 0010 0010 41", grant, ack, fifo_w_data); end
    req = '0;
    after_edge();
  endtask

  task automatic test_prio0();
    logic [N-1:0] expect_next;
`ifdef FIFO_ARB_PRIO0_EN
    expect_next = 4'b0001;
`else
    expect_next = 4'b0100;
`endif
    do_reset();
    req = 4'b1110;
    for (int i = 0; i < N; i++) set_word(i, 8'(8'h60 + i), 1'b0);
    @(negedge clk);
    after_edge();
    for (int w = 0; w < BURST; w++) begin
      @(negedge clk);
      vectors++; if (grant !== 4'b0010) begin miscompares++; $display("[TB] FAIL c6_burst[%0d]: grant %b expected 0010", w, grant); end
      after_edge();
      req[0] = 1'b1;
    end
    @(negedge clk);
    after_edge();
    @(negedge clk);
    vectors++; if (grant !== expect_next) begin miscompares++; $display("[TB] FAIL c6_winner: grant %b expected %b", grant, expect_next); end
    req = '0;
    after_edge();
  endtask

  task automatic test_random();
    int           left[N];
    logic [B-1:0] word[N];
    int           owner;
    int           cnt;
    int           lw;
    int           idx;
    logic [N-1:0] exp_grant;
    logic [N-1:0] exp_ack;
    logic         exp_wr;
    logic         exp_busy;
    logic [N-1:0] ack_seen;
    do_reset();
    owner = -1;
    cnt   = 0;
    lw    = N - 1;
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      word[i] = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (left[i] == 0 && $urandom_range(0, 3) == 0) begin
          left[i] = $urandom_range(1, 6);
          word[i] = 8'($urandom);
        end
        req[i] = (left[i] > 0) && ($urandom_range(0, 15) != 0);
        set_word(i, word[i], (left[i] == 1));
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      exp_grant = '0;
      exp_wr    = 1'b0;
      exp_busy  = (owner >= 0);
      if (owner >= 0) begin
        exp_grant[owner] = 1'b1;
        exp_wr = req[owner] && !fifo_full;
      end
      exp_ack = exp_wr ? exp_grant : '0;
      vectors++; if (grant !== exp_grant) begin miscompares++; $display("[TB] FAIL rnd_grant[%0d]: got %b expected %b", cyc, grant, exp_grant); end
      vectors++; if (ack !== exp_ack) begin miscompares++; $display("[TB] FAIL rnd_ack[%0d]: got %b expected %b", cyc, ack, exp_ack); end
      vectors++; if (fifo_wr !== exp_wr) begin miscompares++; $display("[TB] FAIL rnd_wr[%0d]: got %b expected %b", cyc, fifo_wr, exp_wr); end
      vectors++; if (busy !== exp_busy) begin miscompares++; $display("[TB] FAIL rnd_busy[%0d]: got %b expected %b", cyc, busy, exp_busy); end
      if (exp_wr) begin
        vectors++; if (fifo_w_data !== word[owner]) begin miscompares++; $display("[TB] FAIL rnd_data[%0d]: got %h expected %h", cyc, fifo_w_data, word[owner]); end
      end
      ack_seen = ack;
      if (owner < 0) begin
        if (req != '0) begin
`ifdef FIFO_ARB_PRIO0_EN
          if (req[0]) owner = 0;
`endif
          for (int k = 1; k <= N; k++) begin
            idx = (lw + k) % N;
            if (owner < 0 && req[idx]) owner = idx;
          end
          cnt = 0;
        end
      end else if (!req[owner]) begin
        lw    = owner;
        owner = -1;
      end else if (!fifo_full) begin
        cnt++;
        if (req_last[owner] || cnt == BURST) begin
          lw    = owner;
          owner = -1;
        end
      end
      after_edge();
      for (int i = 0; i < N; i++) begin
        if (ack_seen[i] === 1'b1 && left[i] > 0) begin
          left[i]--;
          word[i] = 8'($urandom);
        end
      end
    end
    req       = '0;
    fifo_full = 1'b0;
    after_edge();
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_full_stall();
    test_reset_mid_burst();
    test_drop_req();
    test_prio0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
